// File: rtl/multicycle_controller.sv
// Multicycle RISC-V main controller: Moore FSM with registered controls.
// Ports: clk, reset(sync, active-high), opcode, Zero -> datapath controls,
//   state (debug), instr_done and illegal_op pulses.
module multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] ImmSrc,
  output logic [3:0] state,
  output logic       instr_done,
  output logic       illegal_op
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  state_t cur;
  state_t nxt;
  state_t tgt;
  logic   legal;
  logic   pc_update;
  logic   branch;
  logic   done_q;

  assign state = cur;

  always_comb begin
    legal = 1'b0;
    case (opcode)
      OP_LW, OP_SW, OP_R,
      OP_I, OP_BEQ, OP_JAL: legal = 1'b1;
      default:              legal = 1'b0;
    endcase
  end

  always_comb begin
    nxt = FETCH;
    case (cur)
      FETCH: nxt = DECODE;
      DECODE: begin
        case (opcode)
          OP_LW, OP_SW: nxt = MEMADR;
          OP_R:         nxt = EXECUTER;
          OP_I:         nxt = EXECUTEI;
          OP_BEQ:       nxt = BEQ;
          OP_JAL:       nxt = JAL;
          default:      nxt = FETCH;
        endcase
      end
      MEMADR:   nxt = (opcode == OP_LW) ? MEMREAD : MEMWRITE;
      MEMREAD:  nxt = MEMWB;
      EXECUTER: nxt = ALUWB;
      EXECUTEI: nxt = ALUWB;
      JAL:      nxt = ALUWB;
      default:  nxt = FETCH;
    endcase
  end

  // Outputs are registered from the state being entered, so they
  // line up with the state register (Moore behaviour, no glitches).
  assign tgt = reset ? FETCH : nxt;

  always_ff @(posedge clk) begin
    cur       <= tgt;
    AdrSrc    <= 1'b0;
    MemWrite  <= 1'b0;
    IRWrite   <= 1'b0;
    RegWrite  <= 1'b0;
    ResultSrc <= 2'b00;
    ALUSrcA   <= 2'b00;
    ALUSrcB   <= 2'b00;
    ALUOp     <= 2'b00;
    pc_update <= 1'b0;
    branch    <= 1'b0;
    done_q    <= 1'b0;
    case (tgt)
      FETCH: begin
        IRWrite   <= 1'b1;
        ALUSrcB   <= 2'b10;
        ResultSrc <= 2'b10;
        pc_update <= 1'b1;
      end
      DECODE: begin
        ALUSrcA <= 2'b01;
        ALUSrcB <= 2'b01;
      end
      MEMADR: begin
        ALUSrcA <= 2'b10;
        ALUSrcB <= 2'b01;
      end
      MEMREAD: begin
        AdrSrc <= 1'b1;
      end
      MEMWB: begin
        ResultSrc <= 2'b01;
        RegWrite  <= 1'b1;
        done_q    <= 1'b1;
      end
      MEMWRITE: begin
        AdrSrc   <= 1'b1;
        MemWrite <= 1'b1;
        done_q   <= 1'b1;
      end
      EXECUTER: begin
        ALUSrcA <= 2'b10;
        ALUOp   <= 2'b10;
      end
      EXECUTEI: begin
        ALUSrcA <= 2'b10;
        ALUSrcB <= 2'b01;
        ALUOp   <= 2'b10;
      end
      ALUWB: begin
        RegWrite <= 1'b1;
        done_q   <= 1'b1;
      end
      BEQ: begin
        ALUSrcA <= 2'b10;
        ALUOp   <= 2'b01;
        branch  <= 1'b1;
        done_q  <= 1'b1;
      end
      JAL: begin
        ALUSrcA   <= 2'b01;
        ALUSrcB   <= 2'b10;
        pc_update <= 1'b1;
      end
      default: ;
    endcase
  end

  assign PCWrite = pc_update | (branch & Zero);

  always_comb begin
    ImmSrc = 2'b00;
    case (opcode)
      OP_SW:   ImmSrc = 2'b01;
      OP_BEQ:  ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

  // Pulses are suppressed while reset is held.
  assign instr_done = done_q & ~reset;
  assign illegal_op = (cur == DECODE) & ~legal & ~reset;

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high; sampled on rising clk edge only.
REQ-003 SHALL have port: opcode  input  7  instr[6:0] from instruction register.
REQ-004 SHALL have port: Zero  input  1  ALU zero flag.
REQ-005 SHALL have ports (outputs, 1 bit each): PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite.
REQ-006 SHALL have ports (outputs, 2 bits each): ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc.
REQ-007 SHALL have port: state  output  4  current FSM state, for debug and bench.
REQ-008 SHALL have port: instr_done  output  1  one-cycle pulse in the final state of each instruction.
REQ-009 SHALL have port: illegal_op  output  1  one-cycle pulse when Decode sees an unsupported opcode.

Function
REQ-010 SHALL implement a Moore FSM with encodings FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BEQ=9, JAL=10; codes 11-15 SHALL go to FETCH on the next edge.
REQ-011 SHALL use these transitions:
- FETCH->DECODE.
- DECODE->MEMADR for opcode 0000011 or 0100011.
- DECODE->EXECUTER for 0110011.
- DECODE->EXECUTEI for 0010011.
- DECODE->BEQ for 1100011.
- DECODE->JAL for 1101111.
- DECODE->FETCH for any other opcode.
REQ-012 SHALL use these transitions:
- MEMADR->MEMREAD when opcode=0000011; MEMADR->MEMWRITE otherwise.
- MEMREAD->MEMWB.
- EXECUTER->ALUWB; EXECUTEI->ALUWB; JAL->ALUWB.
- MEMWB, MEMWRITE, ALUWB, BEQ -> FETCH.
REQ-013 SHALL drive all control outputs 0 in every state except where REQ-014 assigns a value.
REQ-014 SHALL assert, per state:
- FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00.
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00.
- MEMREAD: ResultSrc=00, AdrSrc=1.
- MEMWB: ResultSrc=01, RegWrite=1.
- MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
- ALUWB: ResultSrc=00, RegWrite=1.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1.
REQ-015 SHALL compute PCWrite = PCUpdate | (Branch & Zero) combinationally; PCUpdate and Branch are internal signals.
REQ-016 SHALL decode ImmSrc combinationally from opcode, independent of state: 0000011 or 0010011 -> 00; 0100011 -> 01; 1100011 -> 10; 1101111 -> 11; others -> 00.
REQ-017 SHALL assert instr_done for exactly one cycle while in MEMWB, MEMWRITE, ALUWB or BEQ. JAL instructions signal completion through ALUWB.
REQ-018 SHALL assert illegal_op in DECODE when opcode matches none of the cases in REQ-011.
REQ-019 SHALL take these cycle counts per instruction, FETCH to FETCH: lw 5, sw 4, R-type 4, I-type 4, beq 3, jal 4, illegal 2.
REQ-020 SHALL sample opcode at each edge. Opcode changes mid-instruction affect only the next transition decision; outputs held in the current state do not change.

Reset
REQ-021 SHALL enter FETCH on any clk edge where reset=1, regardless of current state, including mid-instruction.
REQ-022 SHALL, while reset=1, present FETCH output values from the edge after reset is sampled; instr_done=0 and illegal_op=0 during reset.
REQ-023 SHALL, in a cycle where reset=1 and MEMWRITE or RegWrite-asserting state is current, let the reset edge take priority; the held write cycle is allowed to complete.
REQ-024 SHALL, after reset is released, reach DECODE on the first rising edge.

Verification
REQ-025 lw test: reset, then opcode=0000011 -> state sequence 0,1,2,3,4,0; RegWrite=1 only in state 4; ImmSrc=00; instr_done one pulse.
REQ-026 sw test: opcode=0100011 -> sequence 0,1,2,5,0; MemWrite=1 and AdrSrc=1 in state 5 only; ImmSrc=01.
REQ-027 beq test: opcode=1100011 with Zero=1 in BEQ -> PCWrite=1 in state 9. Repeat with Zero=0 -> PCWrite=0 in state 9; ALUOp=01 in both cases.
REQ-028 jal test: opcode=1101111 -> sequence 0,1,10,8,0; PCWrite=1 in states 0 and 10; ImmSrc=11.
REQ-029 illegal opcode test: opcode=1111111 -> sequence 0,1,0; illegal_op=1 only in state 1; no RegWrite or MemWrite pulses.
REQ-030 mid-instruction reset test: reset=1 asserted during state 3 of a lw -> state=0 next edge; RegWrite never asserted; ALUSrcB=10 and IRWrite=1 after the edge.
